edge_pulse_array: RTL
=====================

Name: edge_pulse_array

Overview:
Multi-channel input conditioner for push-buttons and slow external strobes. Each channel synchronises an asynchronous input, debounces it, and emits a single-cycle pulse on a selectable edge.
This block is the parametrised successor to the single-channel rising-edge pulse generator: it adds per-channel rise/fall/both/off modes, a debounce filter and configurable synchroniser depth.
It sits between the board input pins and the control FSMs in the input subsystem.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=1)
DEBOUNCE_CYCLES, 16, consecutive cycles of disagreement needed to accept a new level (>=1; 1 = no filtering)
REPEAT_DELAY, 1000, cycles from the initial rise pulse to the first auto-repeat pulse (used only with PULSE_REPEAT_EN)
REPEAT_PERIOD, 250, cycles between subsequent auto-repeat pulses (used only with PULSE_REPEAT_EN)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
in  input  CHANNELS  raw asynchronous inputs
mode  input  2*CHANNELS  per-channel edge select; bits [2i+1:2i] belong to channel i: 00 off, 01 rise, 10 fall, 11 both
level  output  CHANNELS  debounced, registered level per channel
pulse  output  CHANNELS  single-cycle edge pulse per channel
any_pulse  output  1  registered OR of the next-state pulse vector; asserts in the same cycle as pulse

Behaviour:
- Reset: while reset is high at a posedge, all of the following clear to 0: synchroniser flops, debounce counters, level, pulse, any_pulse and repeat counters. Reset takes priority over every other event.
- Synchroniser: sync[i] is a SYNC_STAGES-deep shift register; s[i] denotes its last stage.
- Debounce, per channel, with counter width $clog2(DEBOUNCE_CYCLES+1):
  - If s == level, the counter goes to 0.
  - Otherwise the counter increments. When it would reach DEBOUNCE_CYCLES, level <= s and the counter goes to 0.
  - Any agreement cycle restarts the count, so a glitch shorter than DEBOUNCE_CYCLES cycles never changes level.
- Edge detection: rise = level change 0->1, fall = level change 1->0, evaluated on the same posedge that updates level.
  - pulse[i] <= (rise & mode[2i]) | (fall & mode[2i+1]).
  - pulse is high for exactly one cycle per accepted edge.
- Latency: when in[i] first settles before posedge k, level changes at posedge k+SYNC_STAGES-1+DEBOUNCE_CYCLES and pulse goes high at the same posedge. Total latency is SYNC_STAGES+DEBOUNCE_CYCLES-1 cycles from the sampling edge.
- Mode:
  - mode is sampled on the edge-detect posedge only. Changing mode never generates a pulse by itself.
  - Mode 00 suppresses pulses; level still tracks the input.
- Channels are fully independent. Simultaneous edges on several channels each pulse, and any_pulse is a single cycle high.
- Input held high through reset: level starts at 0 after reset, so one rise pulse is emitted after the normal latency if rise is enabled.

Optional Feature:
PULSE_REPEAT_EN (auto-repeat, per channel)
- With the macro defined:
  - While level[i]==1 and mode[2i]==1, a repeat counter runs from the initial rise pulse.
  - The first extra pulse occurs REPEAT_DELAY cycles after the initial pulse; further pulses follow every REPEAT_PERIOD cycles.
  - level falling or rise being disabled clears the counter immediately, with no pending pulse.
  - A fall pulse and a repeat pulse in the same cycle merge into one pulse.
- Without the macro: no repeat logic is synthesised, and REPEAT_* parameters are ignored.

Test Plan:
- Defaults with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, mode=all 01; in[0] 0->1 sampled at posedge 10 -> level[0] rises at posedge 15; pulse[0] and any_pulse high for one cycle, sampled high at posedge 16; no other channel pulses.
- in[1] high for 3 cycles then low, mode 11 -> level[1] stays 0, pulse[1] never asserts; a 4-cycle high pulse -> level[1] rises, then one rise pulse and, 4 cycles after return to 0, one fall pulse.
- mode ch2=10, ch3=00; toggle in[2] and in[3] 0->1->0 with 20-cycle holds -> pulse[2] only on the falling edge; pulse[3] never asserts; level[3] follows the input.
- in[0] held high and reset asserted for 3 cycles mid-stream -> all outputs 0 at the posedges where reset is high; after release, one rise pulse at the latency from the first non-reset sample.
- All four channels rise on the same cycle -> pulse=4'b1111 for one cycle, any_pulse high for exactly one cycle.
- With PULSE_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5, in[0] held high -> pulses at T, T+10, T+15, T+20; release -> no further pulses, and the counter restarts on the next press.

Source files
------------

// File: rtl/edge_pulse_array.sv
// Multi-channel input conditioner: synchroniser, debounce filter and selectable edge pulse per channel.
// Optional auto-repeat of rise pulses while a channel is held high is enabled by defining PULSE_REPEAT_EN.
module edge_pulse_array #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   in,
  input  logic [2*CHANNELS-1:0] mode,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   pulse,
  output logic                  any_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [CHANNELS-1:0]                  level_q, level_d;
  logic [CHANNELS-1:0]                  pulse_q, pulse_d;
  logic                                 any_pulse_q, any_pulse_d;
  logic [CHANNELS-1:0]                  rise, fall;

`ifdef PULSE_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [CHANNELS-1:0][RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [CHANNELS-1:0]         rep_act_q, rep_act_d;
  logic [CHANNELS-1:0]         rep_per_q, rep_per_d;
  logic [CHANNELS-1:0]         rep_pulse;
`endif

  always_comb begin
    sync_d      = '0;
    cnt_d       = '0;
    level_d     = level_q;
    rise        = '0;
    fall        = '0;
    pulse_d     = '0;
`ifdef PULSE_REPEAT_EN
    rep_cnt_d   = '0;
    rep_act_d   = '0;
    rep_per_d   = '0;
    rep_pulse   = '0;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      sync_d[i][0] = in[i];
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_d[i][s] = sync_q[i][s-1];
      end

      // Any cycle where the synchronised input agrees with level restarts the count.
      if (sync_q[i][SYNC_STAGES-1] != level_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          level_d[i] = sync_q[i][SYNC_STAGES-1];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end

      rise[i]    = level_d[i] & ~level_q[i];
      fall[i]    = ~level_d[i] & level_q[i];
      pulse_d[i] = (rise[i] & mode[2*i]) | (fall[i] & mode[2*i+1]);

`ifdef PULSE_REPEAT_EN
      // Counter is armed by the initial rise pulse; dropping level or rise-enable disarms it at once.
      if (!level_d[i] || !mode[2*i]) begin
        rep_act_d[i] = 1'b0;
      end else if (rise[i]) begin
        rep_act_d[i] = 1'b1;
      end else if (rep_act_q[i]) begin
        rep_act_d[i] = 1'b1;
        rep_per_d[i] = rep_per_q[i];
        if ((!rep_per_q[i] && rep_cnt_q[i] == DELAY_LAST) ||
            ( rep_per_q[i] && rep_cnt_q[i] == PERIOD_LAST)) begin
          rep_pulse[i] = 1'b1;
          rep_per_d[i] = 1'b1;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
        end
      end
      pulse_d[i] = pulse_d[i] | rep_pulse[i];
`endif
    end
    any_pulse_d = |pulse_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      level_q     <= '0;
      pulse_q     <= '0;
      any_pulse_q <= 1'b0;
`ifdef PULSE_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_act_q   <= '0;
      rep_per_q   <= '0;
`endif
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      pulse_q     <= pulse_d;
      any_pulse_q <= any_pulse_d;
`ifdef PULSE_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_act_q   <= rep_act_d;
      rep_per_q   <= rep_per_d;
`endif
    end
  end

  assign level     = level_q;
  assign pulse     = pulse_q;
  assign any_pulse = any_pulse_q;

endmodule
